// File: rtl/hdmi_line_fetch_ctrl.sv
// hdmi_line_fetch_ctrl: fetches one video line per transmitter request as a
// series of Avalon-MM burst reads from the front frame buffer, and manages
// front/back buffer swapping and the frame-ready flag.
// Optional feature macro: HDMI_FETCH_OVERRUN_DET_EN (adds the sticky overrun_o
// flag and a saturating dropped-request counter).
module hdmi_line_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned WORDS_PER_LINE  = 1280,
  parameter int unsigned LINES           = 720,
  parameter int unsigned BURST_LEN       = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] FB0_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] FB1_BASE = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  line_request_i,
  input  logic                  wr_frame_done_i,
  output logic                  wr_buffer_sel_o,
  output logic                  frame_buffer_ready_o,
  output logic                  line_busy_o,
  output logic                  line_done_o,
  output logic [ADDR_WIDTH-1:0] avm_address_o,
  output logic                  avm_read_o,
  output logic [7:0]            avm_burstcount_o,
  input  logic                  avm_waitrequest_i,
  input  logic                  avm_readdatavalid_i
`ifdef HDMI_FETCH_OVERRUN_DET_EN
  ,
  output logic                  overrun_o
`endif
);

  localparam int unsigned BURSTS = WORDS_PER_LINE / BURST_LEN;
  localparam int unsigned BIDX_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned RET_W  = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  front_q, front_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  swap_pend_q, swap_pend_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  read_q, read_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
  logic [BIDX_W-1:0]     burst_idx_q, burst_idx_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [RET_W-1:0]      ret_cnt_q, ret_cnt_d;
  logic                  accept;
  logic                  burst_done;
  logic [ADDR_WIDTH-1:0] word_off;
`ifdef HDMI_FETCH_OVERRUN_DET_EN
  logic                  overrun_q, overrun_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
`endif

  // Next-state logic: fetch sequencing, return counting, buffer swap
  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    swap_pend_d   = swap_pend_q | wr_frame_done_i;
    ready_d       = ready_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    read_d        = read_q;
    addr_d        = addr_q;
    line_cnt_d    = line_cnt_q;
    burst_idx_d   = burst_idx_q;
    outstanding_d = outstanding_q;
    beat_cnt_d    = beat_cnt_q;
    ret_cnt_d     = ret_cnt_q + RET_W'(avm_readdatavalid_i);
    word_off      = '0;
`ifdef HDMI_FETCH_OVERRUN_DET_EN
    overrun_d     = overrun_q;
    drop_cnt_d    = drop_cnt_q;
`endif

    accept     = read_q & ~avm_waitrequest_i;
    burst_done = avm_readdatavalid_i & (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

    if (avm_readdatavalid_i) begin
      beat_cnt_d = burst_done ? '0 : beat_cnt_q + BEAT_W'(1);
    end

    // Simultaneous issue and completion cancel out
    if (accept && !burst_done) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!accept && burst_done) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (!enable_i) begin
          line_cnt_d = '0;
        end else if (line_request_i) begin
          // Swap only at a frame boundary so a frame is never torn
          if ((line_cnt_q == '0) && (swap_pend_q || wr_frame_done_i)) begin
            front_d     = ~front_q;
            swap_pend_d = 1'b0;
            ready_d     = 1'b1;
          end
          burst_idx_d = '0;
          ret_cnt_d   = '0;
          busy_d      = 1'b1;
          read_d      = (outstanding_d < OUT_W'(MAX_OUTSTANDING));
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (accept && (burst_idx_q == BIDX_W'(BURSTS - 1))) begin
          read_d  = 1'b0;
          state_d = DRAIN;
        end else begin
          if (accept) begin
            burst_idx_d = burst_idx_q + BIDX_W'(1);
          end
          read_d = (outstanding_d < OUT_W'(MAX_OUTSTANDING));
        end
      end
      DRAIN: begin
        if (ret_cnt_d == RET_W'(WORDS_PER_LINE)) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          line_cnt_d = (line_cnt_q == LINE_W'(LINES - 1)) ? '0 : line_cnt_q + LINE_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address only moves while issuing, so it is stable under waitrequest
    if (state_d == ISSUE) begin
      word_off = ADDR_WIDTH'(line_cnt_d) * ADDR_WIDTH'(WORDS_PER_LINE)
               + ADDR_WIDTH'(burst_idx_d) * ADDR_WIDTH'(BURST_LEN);
      addr_d   = (front_d ? FB1_BASE : FB0_BASE) + (word_off << 2);
    end

    wr_sel_d = ~front_d;

`ifdef HDMI_FETCH_OVERRUN_DET_EN
    if (line_request_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      front_q       <= 1'b0;
      wr_sel_q      <= 1'b1;
      swap_pend_q   <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      read_q        <= 1'b0;
      addr_q        <= '0;
      line_cnt_q    <= '0;
      burst_idx_q   <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      ret_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      wr_sel_q      <= wr_sel_d;
      swap_pend_q   <= swap_pend_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      read_q        <= read_d;
      addr_q        <= addr_d;
      line_cnt_q    <= line_cnt_d;
      burst_idx_q   <= burst_idx_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
    end
  end

`ifdef HDMI_FETCH_OVERRUN_DET_EN
  // Sticky overrun flag and dropped-request debug counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overrun_o = overrun_q;
`endif

  assign wr_buffer_sel_o      = wr_sel_q;
  assign frame_buffer_ready_o = ready_q;
  assign line_busy_o          = busy_q;
  assign line_done_o          = done_q;
  assign avm_address_o        = addr_q;
  assign avm_read_o           = read_q;
  assign avm_burstcount_o     = 8'(BURST_LEN);

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed bench for hdmi_line_fetch_ctrl with a small Avalon read-slave model.
// LINES is reduced so a full frame wrap fits in a short run.
module tb_hdmi_line_fetch_ctrl;

  localparam int unsigned TB_LINES = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        line_request_i;
  logic        wr_frame_done_i;
  logic        wr_buffer_sel_o;
  logic        frame_buffer_ready_o;
  logic        line_busy_o;
  logic        line_done_o;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic [7:0]  avm_burstcount_o;
  logic        avm_waitrequest_i;
  logic        avm_readdatavalid_i;
`ifdef HDMI_FETCH_OVERRUN_DET_EN
  logic        overrun_o;
`endif

  hdmi_line_fetch_ctrl #(.LINES(TB_LINES)) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable_i             (enable_i),
    .line_request_i       (line_request_i),
    .wr_frame_done_i      (wr_frame_done_i),
    .wr_buffer_sel_o      (wr_buffer_sel_o),
    .frame_buffer_ready_o (frame_buffer_ready_o),
    .line_busy_o          (line_busy_o),
    .line_done_o          (line_done_o),
    .avm_address_o        (avm_address_o),
    .avm_read_o           (avm_read_o),
    .avm_burstcount_o     (avm_burstcount_o),
    .avm_waitrequest_i    (avm_waitrequest_i),
    .avm_readdatavalid_i  (avm_readdatavalid_i)
`ifdef HDMI_FETCH_OVERRUN_DET_EN
    ,
    .overrun_o            (overrun_o)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_issue = 0;
  int          pending = 0;
  int          beats_line = 0;
  int          done_beats = 0;
  bit          ret_en = 1'b0;
  bit          done_seen = 1'b0;
  bit          done_rdv = 1'b0;
  bit          done_busy = 1'b0;
  bit          rdv_edge = 1'b0;
  logic [31:0] addr_log [0:31];
  int          issue_cyc [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log accepted commands and returned beats, then drive next return
  task automatic step();
    rdv_edge = avm_readdatavalid_i;
    if (avm_read_o && !avm_waitrequest_i) begin
      if (n_issue < 32) begin
        addr_log[n_issue]  = avm_address_o;
        issue_cyc[n_issue] = cyc;
      end
      n_issue++;
      pending += 64;
    end
    if (avm_readdatavalid_i) begin
      pending--;
      beats_line++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (line_done_o && !done_seen) begin
      done_seen  = 1'b1;
      done_beats = beats_line;
      done_rdv   = rdv_edge;
      done_busy  = line_busy_o;
    end
    avm_readdatavalid_i = ret_en && (pending > 0);
  endtask

  task automatic start_line();
    n_issue        = 0;
    beats_line     = 0;
    done_seen      = 1'b0;
    done_rdv       = 1'b0;
    line_request_i = 1'b1;
    step();
    line_request_i = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int k;
    k = 0;
    while (!done_seen && k < 4000) begin
      step();
      k++;
    end
    chk({tag, " done_seen"}, 64'(done_seen), 64'd1);
    chk({tag, " beats"}, 64'(done_beats), 64'd1280);
    chk({tag, " done_after_last_beat"}, 64'(done_rdv), 64'd1);
    chk({tag, " busy_low_at_done"}, 64'(done_busy), 64'd0);
    chk({tag, " bursts"}, 64'(n_issue), 64'd20);
    step();
    chk({tag, " done_one_cycle"}, 64'(line_done_o), 64'd0);
  endtask

  initial begin
    int k;
    int bad;
    reset               = 1'b1;
    enable_i            = 1'b0;
    line_request_i      = 1'b0;
    wr_frame_done_i     = 1'b0;
    avm_waitrequest_i   = 1'b0;
    avm_readdatavalid_i = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst read", 64'(avm_read_o), 64'd0);
    chk("rst addr", 64'(avm_address_o), 64'd0);
    chk("rst busy", 64'(line_busy_o), 64'd0);
    chk("rst done", 64'(line_done_o), 64'd0);
    chk("rst ready", 64'(frame_buffer_ready_o), 64'd0);
    chk("rst wr_sel", 64'(wr_buffer_sel_o), 64'd1);
    chk("burstcount", 64'(avm_burstcount_o), 64'd64);
`ifdef HDMI_FETCH_OVERRUN_DET_EN
    chk("rst overrun", 64'(overrun_o), 64'd0);
`endif

    reset    = 1'b0;
    enable_i = 1'b1;
    ret_en   = 1'b1;
    step();

    // Line 0: free-running memory
    start_line();
    chk("l0 read_rise", 64'(avm_read_o), 64'd1);
    chk("l0 busy_rise", 64'(line_busy_o), 64'd1);
    chk("l0 first_addr", 64'(avm_address_o), 64'h0);
    run_to_done("l0");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (addr_log[i] !== 32'(i * 256)) bad++;
    end
    chk("l0 addr_seq_errors", 64'(bad), 64'd0);
    chk("l0 last_addr", 64'(addr_log[19]), 64'h1300);
    chk("l0 back_to_back", 64'(issue_cyc[3] - issue_cyc[0]), 64'd3);

    // Line 1: waitrequest held for 5 cycles on burst 3
    start_line();
    k = 0;
    while (n_issue < 3 && k < 100) begin
      step();
      k++;
    end
    avm_waitrequest_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l1 wait addr", 64'(avm_address_o), 64'h1700);
      chk("l1 wait read", 64'(avm_read_o), 64'd1);
      chk("l1 wait no_issue", 64'(n_issue), 64'd3);
    end
    avm_waitrequest_i = 1'b0;
    run_to_done("l1");
    chk("l1 burst3", 64'(addr_log[3]), 64'h1700);
    chk("l1 burst4", 64'(addr_log[4]), 64'h1800);
    chk("l1 last", 64'(addr_log[19]), 64'h2700);

    // Line 2: withheld returns cap outstanding bursts at 4
    ret_en = 1'b0;
    start_line();
    repeat (20) step();
    chk("l2 capped_issues", 64'(n_issue), 64'd4);
    chk("l2 read_low", 64'(avm_read_o), 64'd0);
    chk("l2 burst3", 64'(addr_log[3]), 64'h2B00);
    ret_en = 1'b1;
    k = 0;
    while (n_issue < 5 && k < 300) begin
      step();
      k++;
    end
    chk("l2 fifth_issue", 64'(n_issue), 64'd5);
    chk("l2 burst4", 64'(addr_log[4]), 64'h2C00);
    run_to_done("l2");

    // Line 3: mid-frame swap request, and a dropped request during drain
    start_line();
    chk("l3 first_addr", 64'(avm_address_o), 64'h3C00);
    wr_frame_done_i = 1'b1;
    step();
    wr_frame_done_i = 1'b0;
    k = 0;
    while (!(n_issue == 20 && !avm_read_o) && k < 3000) begin
      step();
      k++;
    end
    chk("l3 draining", 64'(line_busy_o), 64'd1);
    line_request_i = 1'b1;
    step();
    line_request_i = 1'b0;
    chk("l3 drop read", 64'(avm_read_o), 64'd0);
`ifdef HDMI_FETCH_OVERRUN_DET_EN
    chk("l3 overrun", 64'(overrun_o), 64'd1);
`endif
    run_to_done("l3");
    repeat (5) step();
    chk("l3 idle read", 64'(avm_read_o), 64'd0);
    chk("l3 idle busy", 64'(line_busy_o), 64'd0);
    chk("l3 ready_pending", 64'(frame_buffer_ready_o), 64'd0);
    chk("l3 wr_sel_pending", 64'(wr_buffer_sel_o), 64'd1);

    // Lines 4 and 5 stay on buffer 0
    start_line();
    chk("l4 first_addr", 64'(avm_address_o), 64'h5000);
    run_to_done("l4");
    start_line();
    chk("l5 first_addr", 64'(avm_address_o), 64'h6400);
    chk("l5 ready", 64'(frame_buffer_ready_o), 64'd0);
    run_to_done("l5");

    // Wrap to line 0 swaps to buffer 1
    start_line();
    chk("wrap first_addr", 64'(avm_address_o), 64'h0040_0000);
    chk("wrap ready", 64'(frame_buffer_ready_o), 64'd1);
    chk("wrap wr_sel", 64'(wr_buffer_sel_o), 64'd0);
    run_to_done("wrap");
    chk("wrap last", 64'(addr_log[19]), 64'h0040_1300);

    // Reset in the middle of issuing
    start_line();
    chk("rl first_addr", 64'(avm_address_o), 64'h0040_1400);
    step();
    step();
    chk("rl issuing", 64'(avm_read_o), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst read", 64'(avm_read_o), 64'd0);
    chk("mid_rst addr", 64'(avm_address_o), 64'd0);
    chk("mid_rst busy", 64'(line_busy_o), 64'd0);
    chk("mid_rst ready", 64'(frame_buffer_ready_o), 64'd0);
    chk("mid_rst wr_sel", 64'(wr_buffer_sel_o), 64'd1);
`ifdef HDMI_FETCH_OVERRUN_DET_EN
    chk("mid_rst overrun", 64'(overrun_o), 64'd0);
`endif
    pending             = 0;
    avm_readdatavalid_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    start_line();
    chk("post_rst addr", 64'(avm_address_o), 64'h0);
    run_to_done("post_rst");
    chk("post_rst last", 64'(addr_log[19]), 64'h1300);

    // Disable in idle drops the request and rewinds to line 0
    enable_i       = 1'b0;
    line_request_i = 1'b1;
    step();
    line_request_i = 1'b0;
    chk("dis read", 64'(avm_read_o), 64'd0);
    chk("dis busy", 64'(line_busy_o), 64'd0);
    enable_i = 1'b1;
    start_line();
    chk("dis line0_addr", 64'(avm_address_o), 64'h0);
    run_to_done("dis");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
